// File: rtl/bky_shift_ctrl.sv
// ============================================================================
// Module : bky_shift_ctrl
// Shifts six Buckeye config registers in parallel. The BKY_READBACK_EN macro
// enables capture of AMPOUT into per-chip readback buffers.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bky_shift_ctrl #(
  parameter int CLK_DIV = 4,
  parameter int NBITS   = 48
) (
  input  logic             CMSCLK,
  input  logic             RST_B,
  input  logic             START,
  input  logic [5:0]       MASK,
  input  logic             WR_EN,
  input  logic [2:0]       WR_CHIP,
  input  logic [NBITS-1:0] DIN,
  input  logic [2:0]       RD_CHIP,
  output logic [NBITS-1:0] DOUT,
  input  logic [5:0]       AMPOUT,
  output logic [5:0]       AMPIN,
  output logic [5:0]       AMPCLK,
  output logic             BUSY,
  output logic             DONE
);

  localparam int            CW         = $clog2(NBITS);
  localparam logic [3:0]    c_div_last = 4'(CLK_DIV - 1);
  localparam logic [CW-1:0] c_cnt_last = CW'(NBITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    FIN  = 2'd3
  } state_t;

  state_t           r_state;
  logic [3:0]       r_div;
  logic [CW-1:0]    r_cnt;
  logic [5:0]       r_msk;
  logic [5:0]       r_ampin;
  logic [5:0]       r_ampclk;
  logic             r_busy;
  logic             r_done;
  logic [NBITS-1:0] r_wbuf [6];
  logic             w_div_last;

  assign w_div_last = (r_div == c_div_last);
  assign AMPIN      = r_ampin;
  assign AMPCLK     = r_ampclk;
  assign BUSY       = r_busy;
  assign DONE       = r_done;

  // Bit idx of every write buffer, gated by the chip mask.
  function automatic logic [5:0] tx_bits(input logic [CW-1:0] idx, input logic [5:0] m);
    logic [5:0] b;
    b = '0;
    for (int k = 0; k < 6; k++) b[k] = m[k] & r_wbuf[k][idx];
    return b;
  endfunction

  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int k = 0; k < 6; k++) r_wbuf[k] <= '0;
    end else if (WR_EN && (r_state == IDLE) && (WR_CHIP != 3'd0) && (WR_CHIP != 3'd7)) begin
      r_wbuf[WR_CHIP - 3'd1] <= DIN;
    end
  end

  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_cnt    <= '0;
      r_msk    <= '0;
      r_ampin  <= '0;
      r_ampclk <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (START) begin
            if (MASK != 6'd0) begin
              r_msk   <= MASK;
              r_cnt   <= '0;
              r_div   <= '0;
              r_ampin <= tx_bits('0, MASK);
              r_busy  <= 1'b1;
              r_state <= LOW;
            end else begin
              r_done  <= 1'b1;
              r_state <= FIN;
            end
          end
        end
        LOW: begin
          if (w_div_last) begin
            r_div    <= '0;
            r_ampclk <= r_msk;
            r_state  <= HIGH;
          end else begin
            r_div <= r_div + 4'd1;
          end
        end
        HIGH: begin
          if (w_div_last) begin
            r_div    <= '0;
            r_ampclk <= '0;
            r_cnt    <= r_cnt + 1'b1;
            if (r_cnt == c_cnt_last) begin
              r_ampin <= '0;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= FIN;
            end else begin
              r_ampin <= tx_bits(r_cnt + 1'b1, r_msk);
              r_state <= LOW;
            end
          end else begin
            r_div <= r_div + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef BKY_READBACK_EN
  logic [NBITS-1:0] r_rbuf [6];
  logic             w_capture;

  // Sampled on the edge that raises AMPCLK, so this is the chip's pre-shift bit.
  assign w_capture = (r_state == LOW) && w_div_last;

  always_ff @(posedge CMSCLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int k = 0; k < 6; k++) r_rbuf[k] <= '0;
    end else if (w_capture) begin
      for (int k = 0; k < 6; k++) begin
        if (r_msk[k]) r_rbuf[k][r_cnt] <= AMPOUT[k];
      end
    end
  end

  always_comb begin
    DOUT = '0;
    case (RD_CHIP)
      3'd1:    DOUT = r_rbuf[0];
      3'd2:    DOUT = r_rbuf[1];
      3'd3:    DOUT = r_rbuf[2];
      3'd4:    DOUT = r_rbuf[3];
      3'd5:    DOUT = r_rbuf[4];
      3'd6:    DOUT = r_rbuf[5];
      default: DOUT = '0;
    endcase
  end
`else
  logic w_unused_ampout;
  assign w_unused_ampout = ^AMPOUT;
  assign DOUT            = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bky_shift_ctrl.sv
// ============================================================================
// Module : tb_bky_shift_ctrl
// Directed bench for bky_shift_ctrl with a 48-bit shift-register model per chip.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bky_shift_ctrl;

`ifdef BKY_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic        cmsclk = 1'b0;
  logic        rst_b;
  logic        start;
  logic [5:0]  mask;
  logic        wr_en;
  logic [2:0]  wr_chip;
  logic [47:0] din;
  logic [2:0]  rd_chip;
  logic [47:0] dout;
  logic [5:0]  ampout;
  logic [5:0]  ampin;
  logic [5:0]  ampclk;
  logic        busy;
  logic        done;

  logic [47:0] model [6] = '{default: '0};
  int          rise  [6] = '{default: 0};
  int          rise0 [6];
  int          checks = 0;
  int          errors = 0;

  always #5 cmsclk = ~cmsclk;

  bky_shift_ctrl #(.CLK_DIV(4), .NBITS(48)) dut (
    .CMSCLK (cmsclk),
    .RST_B  (rst_b),
    .START  (start),
    .MASK   (mask),
    .WR_EN  (wr_en),
    .WR_CHIP(wr_chip),
    .DIN    (din),
    .RD_CHIP(rd_chip),
    .DOUT   (dout),
    .AMPOUT (ampout),
    .AMPIN  (ampin),
    .AMPCLK (ampclk),
    .BUSY   (busy),
    .DONE   (done)
  );

  // Chip model: LSB-first shift register clocked by its AMPCLK.
  generate
    for (genvar k = 0; k < 6; k++) begin : g_chip
      always @(posedge ampclk[k]) begin
        model[k] <= {ampin[k], model[k][47:1]};
        rise[k]  <= rise[k] + 1;
      end
      assign ampout[k] = model[k][0];
    end
  endgenerate

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [2:0] chip, input logic [47:0] data);
    @(negedge cmsclk);
    wr_en = 1'b1; wr_chip = chip; din = data;
    @(negedge cmsclk);
    wr_en = 1'b0;
  endtask

  task automatic read_dout(input logic [2:0] chip, output logic [47:0] val);
    rd_chip = chip;
    #1;
    val = dout;
  endtask

  // n counts negedges after the START-sampling edge; DONE expected at n = 385.
  task automatic run_shift(input logic [5:0] m, input int pulse_at, output int lat,
                           output int busy_hi, output int extra_done,
                           output logic [5:0] seen_clk, output logic [5:0] seen_in);
    lat = 0; busy_hi = 0; extra_done = 0; seen_clk = '0; seen_in = '0;
    for (int k = 0; k < 6; k++) rise0[k] = rise[k];
    @(negedge cmsclk);
    start = 1'b1; mask = m;
    for (int n = 1; n <= 1000 && lat == 0; n++) begin
      @(negedge cmsclk);
      start = 1'b0; wr_en = 1'b0;
      if (busy) busy_hi++;
      seen_clk |= ampclk;
      seen_in  |= ampin;
      if (done) lat = n;
      if (n == pulse_at) begin
        start = 1'b1; mask = 6'h3F; wr_en = 1'b1; wr_chip = 3'd2; din = '1;
      end
    end
    for (int n = 0; n < 10; n++) begin
      @(negedge cmsclk);
      if (done) extra_done++;
    end
  endtask

  initial begin
    int          lat, bh, xd, dn;
    logic [5:0]  sc, si;
    logic [47:0] rv;

    rst_b = 1'b0; start = 1'b0; mask = '0; wr_en = 1'b0;
    wr_chip = '0; din = '0; rd_chip = 3'd1;
    repeat (3) @(negedge cmsclk);
    check_val("rst_ampclk", ampclk, 6'h0);
    check_val("rst_ampin",  ampin,  6'h0);
    check_val("rst_busy",   busy,   1'b0);
    check_val("rst_done",   done,   1'b0);
    check_val("rst_dout",   dout,   48'h0);
    rst_b = 1'b1;
    @(negedge cmsclk);

    // All six chips, distinct words.
    for (int k = 1; k <= 6; k++) load(3'(k), 48'hA5A5_0000_0000 | 48'(k));
    run_shift(6'h3F, 0, lat, bh, xd, sc, si);
    check_val("all_latency", lat, 385);
    check_val("all_busy_cycles", bh, 384);
    check_val("all_extra_done", xd, 0);
    for (int k = 0; k < 6; k++) begin
      check_val($sformatf("all_model%0d", k + 1), model[k], 48'hA5A5_0000_0000 | 48'(k + 1));
      check_val($sformatf("all_rises%0d", k + 1), rise[k] - rise0[k], 48);
    end

    // Readback of chip 2: first the previous word, then the newly loaded one.
    load(3'd2, 48'h1234_5678_9ABC);
    run_shift(6'h3F, 0, lat, bh, xd, sc, si);
    read_dout(3'd2, rv);
    check_val("rb_first", rv, RB ? 48'hA5A5_0000_0002 : 48'h0);
    check_val("rb_model2_new", model[1], 48'h1234_5678_9ABC);
    load(3'd2, 48'h0);
    run_shift(6'h3F, 0, lat, bh, xd, sc, si);
    read_dout(3'd2, rv);
    check_val("rb_second", rv, RB ? 48'h1234_5678_9ABC : 48'h0);
    check_val("rb_model2_zero", model[1], 48'h0);
    read_dout(3'd5, rv);
    check_val("rb_chip5", rv, RB ? 48'hA5A5_0000_0005 : 48'h0);
    read_dout(3'd7, rv);
    check_val("rb_chip7", rv, 48'h0);

    // Partial mask: chips 1 and 3 only.
    run_shift(6'b000101, 0, lat, bh, xd, sc, si);
    check_val("pm_latency", lat, 385);
    check_val("pm_rises1", rise[0] - rise0[0], 48);
    check_val("pm_rises3", rise[2] - rise0[2], 48);
    check_val("pm_rises2", rise[1] - rise0[1], 0);
    check_val("pm_rises4", rise[3] - rise0[3], 0);
    check_val("pm_clk_unmasked", sc & 6'b111010, 6'h0);
    check_val("pm_in_unmasked",  si & 6'b111010, 6'h0);
    check_val("pm_model1", model[0], 48'hA5A5_0000_0001);
    read_dout(3'd1, rv);
    check_val("pm_rb1", rv, RB ? 48'hA5A5_0000_0001 : 48'h0);
    read_dout(3'd2, rv);
    check_val("pm_rb2_kept", rv, RB ? 48'h1234_5678_9ABC : 48'h0);
    read_dout(3'd4, rv);
    check_val("pm_rb4_kept", rv, RB ? 48'hA5A5_0000_0004 : 48'h0);

    // Empty mask completes immediately.
    run_shift(6'h0, 0, lat, bh, xd, sc, si);
    check_val("m0_latency", lat, 1);
    check_val("m0_busy_cycles", bh, 0);
    check_val("m0_clk_seen", sc, 6'h0);
    check_val("m0_extra_done", xd, 0);

    // START and WR_EN mid-shift (cnt = 10) are ignored.
    run_shift(6'h3F, 85, lat, bh, xd, sc, si);
    check_val("ign_latency", lat, 385);
    check_val("ign_extra_done", xd, 0);
    check_val("ign_busy_cycles", bh, 384);
    check_val("ign_model2", model[1], 48'h0);
    check_val("ign_rises2", rise[1] - rise0[1], 48);

    // Asynchronous reset during the high phase of bit 20.
    @(negedge cmsclk);
    start = 1'b1; mask = 6'h3F;
    @(negedge cmsclk);
    start = 1'b0;
    repeat (165) @(negedge cmsclk);
    check_val("ar_pre_ampclk", ampclk, 6'h3F);
    rd_chip = 3'd1;
    #2 rst_b = 1'b0;
    #1;
    check_val("ar_ampclk", ampclk, 6'h0);
    check_val("ar_ampin",  ampin,  6'h0);
    check_val("ar_busy",   busy,   1'b0);
    check_val("ar_dout",   dout,   48'h0);
    dn = 0;
    repeat (5) begin
      @(negedge cmsclk);
      if (done) dn++;
    end
    check_val("ar_no_done", dn, 0);
    rst_b = 1'b1;
    run_shift(6'h3F, 0, lat, bh, xd, sc, si);
    check_val("ar_fresh_latency", lat, 385);
    check_val("ar_fresh_rises6", rise[5] - rise0[5], 48);
    check_val("ar_fresh_model3", model[2], 48'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
